// File: rtl/compare_flag_debouncer.sv
// Debounces one-hot less/equal/greater comparator flags into a registered
// relation state, with rise/fall events, a saturating crossing counter and error pulses.
module compare_flag_debouncer #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_less,
  input  logic             i_equal,
  input  logic             i_greater,
  input  logic             i_clr_count,
  output logic [1:0]       o_state,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_crossings,
  output logic             o_err
);

  typedef enum logic [1:0] {
    UNKNOWN = 2'b00,
    BELOW   = 2'b01,
    EQUAL   = 2'b10,
    ABOVE   = 2'b11
  } rel_t;

  localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rel_t             state, state_nxt, cand, cand_nxt, cls;
  logic [3:0]       run, run_nxt, run_inc;
  logic             rise_nxt, fall_nxt, err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       flags;
  logic             onehot;

  assign flags   = {i_greater, i_equal, i_less};
  assign onehot  = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  assign o_state = state;

  always_comb begin
    cls = UNKNOWN;
    case (flags)
      3'b001:  cls = BELOW;
      3'b010:  cls = EQUAL;
      3'b100:  cls = ABOVE;
      default: cls = UNKNOWN;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    run_nxt   = run;
    run_inc   = '0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (i_valid && !onehot) begin
      err_nxt = 1'b1;
      run_nxt = '0;
    end else if (i_valid) begin
      if (cls == state) begin
        run_nxt = '0;
      end else begin
        if (cls == cand) begin
          run_inc = run + 4'd1;
        end else begin
          cand_nxt = cls;
          run_inc  = 4'd1;
        end
        // Adopt on the same edge the DEBOUNCE-th agreeing sample is taken.
        if (run_inc == DEB) begin
          state_nxt = cls;
          run_nxt   = '0;
          rise_nxt  = (cls == ABOVE) && (state == BELOW || state == EQUAL);
          fall_nxt  = (cls == BELOW) && (state == ABOVE || state == EQUAL);
        end else begin
          run_nxt = run_inc;
        end
      end
    end

    cnt_nxt = o_crossings;
    if (i_clr_count)
      cnt_nxt = '0;
    else if ((rise_nxt || fall_nxt) && o_crossings != CNT_MAX)
      cnt_nxt = o_crossings + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= UNKNOWN;
      cand        <= UNKNOWN;
      run         <= '0;
      o_rise      <= 1'b0;
      o_fall      <= 1'b0;
      o_err       <= 1'b0;
      o_crossings <= '0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      run         <= run_nxt;
      o_rise      <= rise_nxt;
      o_fall      <= fall_nxt;
      o_err       <= err_nxt;
      o_crossings <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_compare_flag_debouncer.sv
// Bench: three debouncer instances (DEBOUNCE/CNT_W = 3/8, 3/2, 1/8) on shared
// inputs, scenario checks plus a randomized run against a sample-level model.
module tb_compare_flag_debouncer;

  logic i_clk = 1'b0;
  logic i_rst, i_valid, i_less, i_equal, i_greater, i_clr_count;
  logic [1:0] st [3];
  logic       rise [3];
  logic       fall [3];
  logic       err [3];
  logic [7:0] cr0, cr2;
  logic [1:0] cr1;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  compare_flag_debouncer #(.DEBOUNCE(3), .CNT_W(8)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_less(i_less),
    .i_equal(i_equal), .i_greater(i_greater), .i_clr_count(i_clr_count),
    .o_state(st[0]), .o_rise(rise[0]), .o_fall(fall[0]), .o_crossings(cr0), .o_err(err[0]));

  compare_flag_debouncer #(.DEBOUNCE(3), .CNT_W(2)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_less(i_less),
    .i_equal(i_equal), .i_greater(i_greater), .i_clr_count(i_clr_count),
    .o_state(st[1]), .o_rise(rise[1]), .o_fall(fall[1]), .o_crossings(cr1), .o_err(err[1]));

  compare_flag_debouncer #(.DEBOUNCE(1), .CNT_W(8)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_less(i_less),
    .i_equal(i_equal), .i_greater(i_greater), .i_clr_count(i_clr_count),
    .o_state(st[2]), .o_rise(rise[2]), .o_fall(fall[2]), .o_crossings(cr2), .o_err(err[2]));

  // Relation codes: 0 unknown, 1 below, 2 equal, 3 above.
  typedef struct {
    int st, cand, agree, cnt;
    bit rise, fall, err;
  } mdl_t;

  mdl_t m [3];
  int   deb [3]  = '{3, 3, 1};
  int   cmax [3] = '{255, 3, 255};

  function automatic mdl_t mstep(mdl_t p, int d, int cm, bit v, bit l, bit e, bit g, bit clr, bit rst);
    mdl_t r = p;
    int c;
    if (rst) begin
      r = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
      return r;
    end
    r.rise = 0; r.fall = 0; r.err = 0;
    if (v) begin
      if (int'(l) + int'(e) + int'(g) != 1) begin
        r.err = 1;
        r.agree = 0;
      end else begin
        c = l ? 1 : (e ? 2 : 3);
        if (c == p.st) r.agree = 0;
        else begin
          if (c == p.cand) r.agree = p.agree + 1;
          else begin r.cand = c; r.agree = 1; end
          if (r.agree == d) begin
            r.rise  = (c == 3) && (p.st == 1 || p.st == 2);
            r.fall  = (c == 1) && (p.st == 3 || p.st == 2);
            r.st    = c;
            r.agree = 0;
          end
        end
      end
    end
    if (clr) r.cnt = 0;
    else if ((r.rise || r.fall) && r.cnt < cm) r.cnt = r.cnt + 1;
    return r;
  endfunction

  task automatic step(bit v, bit l, bit e, bit g, bit clr = 0, bit rst = 0);
    i_valid = v; i_less = l; i_equal = e; i_greater = g;
    i_clr_count = clr; i_rst = rst;
    @(posedge i_clk);
    for (int k = 0; k < 3; k++) m[k] = mstep(m[k], deb[k], cmax[k], v, l, e, g, clr, rst);
    #1;
  endtask

  task automatic gt();   step(1, 0, 0, 1); endtask
  task automatic lt();   step(1, 1, 0, 0); endtask
  task automatic idle(); step(0, 0, 0, 0); endtask

  task automatic test_reset();
    step(1, 0, 0, 1, 1, 1);
    checks++;
    if (st[0] !== 2'b00 || rise[0] !== 1'b0 || fall[0] !== 1'b0 || err[0] !== 1'b0 || cr0 !== 8'd0) begin
      failures++;
      $display("FAIL reset: state=%b rise=%b fall=%b err=%b cnt=%0d, required 00/0/0/0/0", st[0], rise[0], fall[0], err[0], cr0);
    end
    checks++;
    if (st[2] !== 2'b00 || cr1 !== 2'd0) begin
      failures++;
      $display("FAIL reset_others: state2=%b cnt1=%0d, required 00/0", st[2], cr1);
    end
  endtask

  task automatic test_rise_from_unknown();
    gt();
    checks++;
    if (st[2] !== 2'b11 || rise[2] !== 1'b0) begin
      failures++;
      $display("FAIL deb1_adopt: state=%b rise=%b, required 11/0", st[2], rise[2]);
    end
    gt();
    checks++;
    if (st[0] !== 2'b00) begin
      failures++;
      $display("FAIL early_adopt: state=%b, required 00", st[0]);
    end
    gt();
    checks++;
    if (st[0] !== 2'b11 || rise[0] !== 1'b0 || cr0 !== 8'd0) begin
      failures++;
      $display("FAIL above_from_unknown: state=%b rise=%b cnt=%0d, required 11/0/0", st[0], rise[0], cr0);
    end
  endtask

  task automatic test_fall();
    bit ok = 1;
    lt(); ok &= (st[0] === 2'b11);
    lt(); ok &= (st[0] === 2'b11);
    gt(); ok &= (st[0] === 2'b11);
    lt(); ok &= (st[0] === 2'b11);
    lt(); ok &= (st[0] === 2'b11);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fall_hold: state=%b, required 11 before 3rd consecutive less", st[0]);
    end
    lt();
    checks++;
    if (st[0] !== 2'b01 || fall[0] !== 1'b1 || cr0 !== 8'd1) begin
      failures++;
      $display("FAIL fall: state=%b fall=%b cnt=%0d, required 01/1/1", st[0], fall[0], cr0);
    end
    idle();
    checks++;
    if (fall[0] !== 1'b0 || st[0] !== 2'b01) begin
      failures++;
      $display("FAIL fall_pulse: fall=%b state=%b, required 0/01", fall[0], st[0]);
    end
    checks++;
    if (cr2 !== 8'd3 || st[2] !== 2'b01) begin
      failures++;
      $display("FAIL deb1_crossings: cnt=%0d state=%b, required 3/01", cr2, st[2]);
    end
  endtask

  task automatic test_gap();
    gt();
    for (int i = 0; i < 5; i++) idle();
    gt();
    checks++;
    if (st[0] !== 2'b01) begin
      failures++;
      $display("FAIL gap_hold: state=%b, required 01", st[0]);
    end
    gt();
    checks++;
    if (st[0] !== 2'b11 || rise[0] !== 1'b1 || cr0 !== 8'd2) begin
      failures++;
      $display("FAIL gap_rise: state=%b rise=%b cnt=%0d, required 11/1/2", st[0], rise[0], cr0);
    end
    idle();
    checks++;
    if (rise[0] !== 1'b0) begin
      failures++;
      $display("FAIL rise_pulse: rise=%b, required 0", rise[0]);
    end
  endtask

  task automatic test_err();
    lt(); lt(); lt();
    gt(); gt();
    step(1, 1, 0, 1);
    checks++;
    if (err[0] !== 1'b1 || st[0] !== 2'b01) begin
      failures++;
      $display("FAIL err_101: err=%b state=%b, required 1/01", err[0], st[0]);
    end
    idle();
    checks++;
    if (err[0] !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: err=%b, required 0", err[0]);
    end
    gt(); gt();
    checks++;
    if (st[0] !== 2'b01) begin
      failures++;
      $display("FAIL err_restart: state=%b, required 01 after 2 greaters", st[0]);
    end
    gt();
    checks++;
    if (st[0] !== 2'b11 || rise[0] !== 1'b1 || cr0 !== 8'd4) begin
      failures++;
      $display("FAIL err_then_rise: state=%b rise=%b cnt=%0d, required 11/1/4", st[0], rise[0], cr0);
    end
    step(1, 0, 0, 0);
    checks++;
    if (err[0] !== 1'b1) begin
      failures++;
      $display("FAIL err_000: err=%b, required 1", err[0]);
    end
    step(1, 1, 1, 1);
    checks++;
    if (err[0] !== 1'b1 || st[0] !== 2'b11) begin
      failures++;
      $display("FAIL err_111: err=%b state=%b, required 1/11", err[0], st[0]);
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) gt();
    for (int x = 0; x < 5; x++)
      for (int i = 0; i < 3; i++) if (x % 2 == 0) lt(); else gt();
    checks++;
    if (cr1 !== 2'd3 || cr0 !== 8'd5) begin
      failures++;
      $display("FAIL saturate: cnt2bit=%0d cnt8bit=%0d, required 3/5", cr1, cr0);
    end
    gt(); gt();
    step(1, 0, 0, 1, 1, 0);
    checks++;
    if (cr1 !== 2'd0 || cr0 !== 8'd0 || rise[0] !== 1'b1) begin
      failures++;
      $display("FAIL clr_wins: cnt2bit=%0d cnt8bit=%0d rise=%b, required 0/0/1", cr1, cr0, rise[0]);
    end
  endtask

  task automatic test_mid_reset();
    lt(); lt();
    step(1, 1, 0, 0, 0, 1);
    checks++;
    if (st[0] !== 2'b00 || rise[0] !== 1'b0 || fall[0] !== 1'b0 || err[0] !== 1'b0 || cr0 !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset: state=%b rise=%b fall=%b err=%b cnt=%0d, required 00/0/0/0/0", st[0], rise[0], fall[0], err[0], cr0);
    end
    gt(); gt();
    checks++;
    if (st[0] !== 2'b00) begin
      failures++;
      $display("FAIL run_cleared: state=%b, required 00", st[0]);
    end
  endtask

  task automatic test_random();
    int cls = 3;
    int obs_cr [3];
    bit v, l, e, g;
    step(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 30) cls = $urandom_range(3, 1);
      v = ($urandom_range(3) != 0);
      if ($urandom_range(99) < 8) {l, e, g} = 3'($urandom_range(7));
      else {l, e, g} = (cls == 1) ? 3'b100 : (cls == 2) ? 3'b010 : 3'b001;
      step(v, l, e, g, $urandom_range(99) < 3, $urandom_range(299) == 0);
      obs_cr = '{int'(cr0), int'(cr1), int'(cr2)};
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (st[k] !== 2'(m[k].st) || rise[k] !== m[k].rise || fall[k] !== m[k].fall ||
            err[k] !== m[k].err || obs_cr[k] != m[k].cnt) begin
          failures++;
          $display("FAIL random[%0d] inst%0d: state=%b rise=%b fall=%b err=%b cnt=%0d, required %0d/%0b/%0b/%0b/%0d",
                   n, k, st[k], rise[k], fall[k], err[k], obs_cr[k], m[k].st, m[k].rise, m[k].fall, m[k].err, m[k].cnt);
        end
      end
    end
  endtask

  initial begin
    i_rst = 1; i_valid = 0; i_less = 0; i_equal = 0; i_greater = 0; i_clr_count = 0;
    for (int k = 0; k < 3; k++) m[k] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    test_reset();
    test_rise_from_unknown();
    test_fall();
    test_gap();
    test_err();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
